// File: rtl/intersection_scheduler.sv
// Two-road intersection scheduler: NS/EW greens with min/max timing,
// yellow and all-red clearance, and an all-stop pedestrian walk phase.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_ns, req_ew   vehicle demand levels, sampled every edge
//   ped_req          pedestrian button pulse, latched until served
//   ns_r/ns_y/ns_g   NS lamp head
//   ew_r/ew_y/ew_g   EW lamp head
//   walk             pedestrian walk lamp
//   phase            current state code (debug)
module intersection_scheduler #(
   parameter int T_MIN_G = 16,
   parameter int T_MAX_G = 64,
   parameter int T_Y     = 8,
   parameter int T_AR    = 4,
   parameter int T_WALK  = 32,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_ns,
   input  logic       req_ew,
   input  logic       ped_req,
   output logic       ns_r,
   output logic       ns_y,
   output logic       ns_g,
   output logic       ew_r,
   output logic       ew_y,
   output logic       ew_g,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      AR_EW  = 3'd0,
      NS_G   = 3'd1,
      NS_Y   = 3'd2,
      AR_NS  = 3'd3,
      EW_G   = 3'd4,
      EW_Y   = 3'd5,
      PED    = 3'd6,
      ST_ILL = 3'd7
   } state_e;

   localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(T_MIN_G - 1);
   localparam logic [CNT_W-1:0] MAX_L  = CNT_W'(T_MAX_G - 1);
   localparam logic [CNT_W-1:0] Y_L    = CNT_W'(T_Y - 1);
   localparam logic [CNT_W-1:0] AR_L   = CNT_W'(T_AR - 1);
   localparam logic [CNT_W-1:0] WALK_L = CNT_W'(T_WALK - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ped_pend_q, ped_pend_d;
   logic             ped_ret_q, ped_ret_d;

   logic ns_exit, ew_exit, ped_enter;

   // Leave a green once min green is served and the other side
   // (or a pedestrian) waits; own demand stretches it to max green.
   assign ns_exit = (cnt_q >= MIN_L)
                 && (req_ew || ped_pend_q)
                 && (!req_ns || cnt_q >= MAX_L);

   assign ew_exit = (cnt_q >= MIN_L)
                 && (req_ns || ped_pend_q)
                 && (!req_ew || cnt_q >= MAX_L);

   always_comb begin
      state_d   = state_q;
      ped_ret_d = ped_ret_q;
      case (state_q)
         AR_EW: begin
            if (cnt_q == AR_L) begin
               if (ped_pend_q) begin
                  state_d   = PED;
                  ped_ret_d = 1'b0;
               end else begin
                  state_d = NS_G;
               end
            end
         end
         NS_G: if (ns_exit) state_d = NS_Y;
         NS_Y: if (cnt_q == Y_L) state_d = AR_NS;
         AR_NS: begin
            if (cnt_q == AR_L) begin
               if (ped_pend_q) begin
                  state_d   = PED;
                  ped_ret_d = 1'b1;
               end else begin
                  state_d = EW_G;
               end
            end
         end
         EW_G: if (ew_exit) state_d = EW_Y;
         EW_Y: if (cnt_q == Y_L) state_d = AR_EW;
         PED: begin
            if (cnt_q == WALK_L) begin
               state_d = ped_ret_q ? EW_G : NS_G;
            end
         end
         default: state_d = AR_EW;
      endcase
   end

   assign ped_enter = (state_d == PED) && (state_q != PED);

   always_comb begin
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q == {CNT_W{1'b1}}) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Entering the walk phase consumes the request, even one arriving
   // on the same edge.
   assign ped_pend_d = ped_enter ? 1'b0 : (ped_pend_q || ped_req);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= AR_EW;
         cnt_q      <= '0;
         ped_pend_q <= 1'b0;
         ped_ret_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ped_pend_q <= ped_pend_d;
         ped_ret_q  <= ped_ret_d;
      end
   end

   // Red is the default so the illegal code decodes as all-stop.
   assign ns_g  = (state_q == NS_G);
   assign ns_y  = (state_q == NS_Y);
   assign ns_r  = !(ns_g || ns_y);
   assign ew_g  = (state_q == EW_G);
   assign ew_y  = (state_q == EW_Y);
   assign ew_r  = !(ew_g || ew_y);
   assign walk  = (state_q == PED);
   assign phase = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: segment tables of
// {inputs, cycle count, expected phase} plus async-reset sequence.
module tb_intersection_scheduler;

   logic       clk;
   logic       rst;
   logic       req_ns;
   logic       req_ew;
   logic       ped_req;
   logic       ns_r, ns_y, ns_g;
   logic       ew_r, ew_y, ew_g;
   logic       walk;
   logic [2:0] phase;

   int n_chk;
   int n_fail;

   typedef struct {
      logic       ns;
      logic       ew;
      logic       ped;
      int         n;
      logic [2:0] ph;
   } seg_t;

   seg_t tab[$];

   intersection_scheduler dut (
      .clk     (clk),
      .rst     (rst),
      .req_ns  (req_ns),
      .req_ew  (req_ew),
      .ped_req (ped_req),
      .ns_r    (ns_r),
      .ns_y    (ns_y),
      .ns_g    (ns_g),
      .ew_r    (ew_r),
      .ew_y    (ew_y),
      .ew_g    (ew_g),
      .walk    (walk),
      .phase   (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected lamps {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} per phase.
   function automatic logic [6:0] lamps_of(input logic [2:0] ph);
      case (ph)
         3'd0:    return 7'b100_100_0;
         3'd1:    return 7'b001_100_0;
         3'd2:    return 7'b010_100_0;
         3'd3:    return 7'b100_100_0;
         3'd4:    return 7'b100_001_0;
         3'd5:    return 7'b100_010_0;
         3'd6:    return 7'b100_100_1;
         default: return 7'b100_100_0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [2:0] ph);
      logic [6:0] act;
      logic [6:0] exp;
      act = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk};
      exp = lamps_of(ph);
      n_chk++;
      if (phase !== ph) begin
         n_fail++;
         $display("FAIL %s phase t=%0t got %0d want %0d",
                  nm, $time, phase, ph);
      end
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lamps t=%0t got %b want %b",
                  nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic ns, input logic ew,
                      input logic ped, input int n,
                      input logic [2:0] ph);
      seg_t s;
      s.ns  = ns;
      s.ew  = ew;
      s.ped = ped;
      s.n   = n;
      s.ph  = ph;
      tab.push_back(s);
   endtask

   task automatic run_rows(input string nm, input int lo,
                           input int hi);
      for (int i = lo; i < hi; i++) begin
         req_ns  = tab[i].ns;
         req_ew  = tab[i].ew;
         ped_req = tab[i].ped;
         for (int k = 0; k < tab[i].n; k++) begin
            check($sformatf("%s_row%0d", nm, i), tab[i].ph);
            tick();
         end
      end
      req_ns  = 1'b0;
      req_ew  = 1'b0;
      ped_req = 1'b0;
   endtask

   int a_end, b_end, c_end;

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst     = 1'b1;
      req_ns  = 1'b0;
      req_ew  = 1'b0;
      ped_req = 1'b0;

      // A: idle start, long NS hold, ped paths, max-green cycling
      add(0, 0, 0,   4, 3'd0);
      add(0, 0, 0, 200, 3'd1);
      add(0, 1, 0,   1, 3'd1);
      add(0, 0, 0,   8, 3'd2);
      add(0, 0, 0,   4, 3'd3);
      add(0, 0, 1,   1, 3'd4);
      add(0, 0, 0,  15, 3'd4);
      add(0, 0, 0,   8, 3'd5);
      add(0, 0, 0,   4, 3'd0);
      add(0, 0, 0,  32, 3'd6);
      add(0, 0, 1,   1, 3'd1);
      add(0, 0, 0,  15, 3'd1);
      add(0, 0, 0,   8, 3'd2);
      add(0, 0, 0,   3, 3'd3);
      add(0, 0, 1,   1, 3'd3);
      add(0, 0, 0,  32, 3'd6);
      add(0, 0, 0,   3, 3'd4);
      add(1, 1, 0,  61, 3'd4);
      add(1, 1, 0,   8, 3'd5);
      add(1, 1, 0,   4, 3'd0);
      add(1, 1, 0,  64, 3'd1);
      add(1, 1, 0,   8, 3'd2);
      add(1, 1, 0,   4, 3'd3);
      add(1, 1, 0,  64, 3'd4);
      add(1, 1, 0,   8, 3'd5);
      add(1, 1, 0,   4, 3'd0);
      add(1, 1, 0,   1, 3'd1);
      add(0, 1, 0,  15, 3'd1);
      add(0, 1, 0,   8, 3'd2);
      add(0, 1, 0,   4, 3'd3);
      add(0, 1, 0,   1, 3'd4);
      add(1, 0, 0,  15, 3'd4);
      add(0, 0, 1,   1, 3'd5);
      add(0, 0, 0,   2, 3'd5);
      a_end = tab.size();
      // B: after reset, req_ew held; stale ped must be gone
      add(0, 1, 0,   4, 3'd0);
      add(0, 1, 0,  16, 3'd1);
      add(0, 1, 0,   8, 3'd2);
      add(0, 1, 0,   4, 3'd3);
      add(0, 1, 0,   3, 3'd4);
      b_end = tab.size();
      // C: ped re-armed during PED gives exactly one more PED
      add(1, 0, 0,  13, 3'd4);
      add(1, 0, 0,   8, 3'd5);
      add(1, 0, 0,   4, 3'd0);
      add(0, 0, 1,   1, 3'd1);
      add(0, 0, 0,  15, 3'd1);
      add(0, 0, 0,   8, 3'd2);
      add(0, 0, 0,   4, 3'd3);
      add(0, 0, 0,   5, 3'd6);
      add(0, 0, 1,   1, 3'd6);
      add(0, 0, 0,  26, 3'd6);
      add(0, 0, 0,  16, 3'd4);
      add(0, 0, 0,   8, 3'd5);
      add(0, 0, 0,   4, 3'd0);
      add(0, 0, 0,  32, 3'd6);
      add(0, 0, 0,  40, 3'd1);
      c_end = tab.size();

      repeat (3) @(posedge clk);
      check("in_reset", 3'd0);
      #1;
      rst = 1'b0;

      run_rows("A", 0, a_end);

      // Mid-EW_Y async reset, away from any clock edge
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 3'd0);
      @(posedge clk);
      #1;
      check("rst_hold", 3'd0);
      rst = 1'b0;

      run_rows("B", a_end, b_end);
      run_rows("C", b_end, c_end);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Two-road intersection controller that schedules green time between a north-south (NS) and an east-west (EW) signal head. It uses vehicle demand sensors and a latched pedestrian button. It sits above the per-head lamp drivers: it owns the phase sequence, the min/max green timing, the yellow and all-red clearance intervals, and the all-stop pedestrian walk phase.

## Interface
- T_MIN_G, 16, minimum green length in cycles
- T_MAX_G, 64, maximum green length in cycles when both roads have demand
- T_Y, 8, yellow length in cycles
- T_AR, 4, all-red clearance length in cycles
- T_WALK, 32, pedestrian walk length in cycles
- CNT_W, 8, phase counter width; all T_* are ≥1 and ≤2^CNT_W−1; T_MIN_G ≤ T_MAX_G
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_ns  in  1  NS vehicle demand, level, sampled each edge
- req_ew  in  1  EW vehicle demand, level, sampled each edge
- ped_req  in  1  pedestrian button, ≥1-cycle pulse, latched
- ns_r, ns_y, ns_g  out  1 each  NS lamps
- ew_r, ew_y, ew_g  out  1 each  EW lamps
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding, for debug and verification

## Operation
- State encoding: AR_EW=0, NS_G=1, NS_Y=2, AR_NS=3, EW_G=4, EW_Y=5, PED=6. Code 7 is illegal and goes to AR_EW on the next edge.
- Registers:
  - state
  - cnt (CNT_W bits)
  - ped_pend: latched button
  - ped_ret: the green to serve after PED; 0=NS, 1=EW
- cnt clears to 0 on every state change. Otherwise it increments, saturating at all-ones.
- Demand terms: other_dem = req_ew|ped_pend while in NS_G; req_ns|ped_pend while in EW_G.
- Green exit for NS_G (EW_G is symmetric, with req_ew as own demand):
  - condition: cnt ≥ T_MIN_G−1 AND other_dem AND (!req_ns OR cnt ≥ T_MAX_G−1)
  - own demand extends green up to T_MAX_G
  - with no other demand, green holds indefinitely
- Transitions:
  - NS_G→NS_Y, and EW_G→EW_Y, on the green exit condition.
  - NS_Y→AR_NS, and EW_Y→AR_EW, at cnt==T_Y−1.
  - AR_NS at cnt==T_AR−1: goes to PED with ped_ret=1 if ped_pend, else to EW_G.
  - AR_EW at cnt==T_AR−1: goes to PED with ped_ret=0 if ped_pend, else to NS_G.
  - PED at cnt==T_WALK−1: goes to EW_G if ped_ret, else to NS_G.
- Vehicle greens always alternate. A road gets its green turn even with no demand on it; min-green still applies.
- ped_pend:
  - set by ped_req
  - cleared on the edge that enters PED; the clear wins over a simultaneous ped_req
  - ped_req during PED (after entry) re-arms it for the next cycle
- Outputs are decoded combinationally from state. Exactly one lamp per head is on at any time.
  - Red lamps:
    - ns_r=1 in AR_EW, EW_G, EW_Y, AR_NS and PED
    - ew_r=1 in AR_EW, NS_G, NS_Y, AR_NS and PED
  - Green and yellow lamps:
    - ns_g=1 only in NS_G; ns_y=1 only in NS_Y
    - ew_g and ew_y follow the same pattern in EW_G and EW_Y
  - walk=1 only in PED
  - Illegal code 7 decodes as all red, walk=0.

## Timing
- Reset values:
  - state=AR_EW, cnt=0, ped_pend=0, ped_ret=0
  - outputs: ns_r=ew_r=1, all other lamps 0, walk=0, phase=0
- Reset asserted mid-phase forces reset values immediately and asynchronously. Any latched pedestrian request is discarded.
- Fixed phases (Y, AR, PED) each last exactly T_* cycles.
- A green lasts at least T_MIN_G cycles.
- Demand asserted in the cycle that satisfies the exit condition takes effect on that same edge. The next state is visible one cycle later.
- Cycle numbering: cycle 0 is the first edge after rst deasserts.
- The first green (NS) begins after T_AR cycles: ns_g rises after the 4th edge with defaults.

## Test plan
- Reset release, no inputs:
  - phase=0, ns_r=ew_r=1 for 4 cycles
  - then NS_G held indefinitely
  - ew_r stays 1 and walk stays 0
- req_ew held high, req_ns low, from reset:
  - NS green 16 cycles, NS_Y 8, AR_NS 4, then EW_G
  - counting from NS_G entry, ns_g lasts exactly 16 cycles and ew_g rises on cycle 28
- req_ns and req_ew both held high:
  - every green lasts exactly 64 cycles
  - sequence repeats NS_G(64) NS_Y(8) AR_NS(4) EW_G(64) EW_Y(8) AR_EW(4)
- In NS_G with no demand, held 200 cycles, then 1-cycle req_ew pulse on cycle 200:
  - phase=2 (NS_Y) on cycle 201
- One-cycle ped_req during NS_G, no vehicle demand:
  - after min green: NS_Y 8, AR_NS 4
  - PED 32 cycles with walk=1 and both heads red, then EW_G
  - ped_pend=0 after PED entry
- Reset and edge cases:
  - rst pulsed mid-EW_Y: outputs all-red and phase=0 immediately; restart matches the first scenario
  - ped_req pulsed during PED: exactly one further PED after the following EW_G/EW_Y/AR_EW
